// File: rtl/ptm_scan_ctrl_pkg.sv
// ptm_scan_ctrl_pkg
//   Shared definitions for the pattern-match scan controller:
//   default widths, ROM read latency and the scheduler FSM encoding.
package ptm_scan_ctrl_pkg;

    localparam int AW_DEF  = 10;   // ROM address / command length width
    localparam int DW_DEF  = 10;   // ROM data width
    localparam int CW_DEF  = 10;   // per-job hit counter width
    localparam int ROM_LAT = 1;    // cycles from rom_en to rom_data

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/ptm_cmd_fifo.sv
// ptm_cmd_fifo
//   Small synchronous FIFO holding queued scan commands ({id, base, len}).
//   Ports:
//     clk, rst             clock and synchronous active-high reset
//     push, push_data      write request and data (ignored when full)
//     pop                  read request (ignored when empty)
//     pop_data             head entry, valid whenever empty=0
//     full, empty          occupancy flags
module ptm_cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ptm_scan_ctrl.sv
// ptm_scan_ctrl
//   Job scheduler in front of the bit-serial pattern-match engine. Queues
//   scan commands, streams the addressed ROM words (bit 0) to the engine one
//   per cycle, counts engine hits per job and returns tagged counts in
//   command order.
//   Ports:
//     clk, rst                                   clock, synchronous reset
//     cmd_valid/cmd_base/cmd_len/cmd_ready       command push interface
//     rom_en/rom_addr/rom_data                   ROM read port (1-cycle latency)
//     eng_clr/eng_valid/eng_bit/eng_hit          engine interface
//     res_valid/res_ready/res_id/res_count       result interface
//     busy                                       work pending or in flight
module ptm_scan_ctrl
    import ptm_scan_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int QD = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    output logic          cmd_ready,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          eng_clr,
    output logic          eng_valid,
    output logic          eng_bit,
    input  logic          eng_hit,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [IW-1:0] res_id,
    output logic [CW-1:0] res_count,
    output logic          busy
);

    localparam int FW = IW + 2 * AW;

    state_t             state_q, state_d;
    logic [AW-1:0]      base_q, base_d;
    logic [AW-1:0]      len_q, len_d;
    logic [AW-1:0]      off_q, off_d;
    logic [IW-1:0]      job_id_q, job_id_d;
    logic [IW-1:0]      id_cnt_q, id_cnt_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ROM_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [ROM_LAT:0]   rd_pipe_shift;

    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [FW-1:0]      fifo_rd;
    logic [AW-1:0]      fifo_len;
    logic               rom_data_unused;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign fifo_len  = fifo_rd[AW-1:0];

    ptm_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (QD)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({id_cnt_q, cmd_base, cmd_len}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // eng_valid tracks rom_en through the ROM read latency.
    assign rd_pipe_shift = {rd_pipe_q, rom_en};

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        off_d     = off_q;
        job_id_d  = job_id_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        id_cnt_d  = push ? id_cnt_q + IW'(1) : id_cnt_q;
        rd_pipe_d = rd_pipe_shift[ROM_LAT-1:0];

        // Saturating hit counter; eng_hit is meaningless without eng_valid.
        if (eng_valid && eng_hit && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + CW'(1);

        case (state_q)
            // A command being pushed this cycle counts as pending, so a job
            // into an idle controller starts on the following cycle.
            ST_IDLE: begin
                if (!fifo_empty || push) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop = 1'b1;
                {job_id_d, base_d, len_d} = fifo_rd;
                off_d   = '0;
                cnt_d   = '0;
                state_d = (fifo_len == '0) ? ST_REPORT : ST_RUN;
            end
            ST_RUN: begin
                off_d = off_q + AW'(1);
                if (off_q == len_q - AW'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            off_q     <= '0;
            job_id_q  <= '0;
            id_cnt_q  <= '0;
            cnt_q     <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            off_q     <= off_d;
            job_id_q  <= job_id_d;
            id_cnt_q  <= id_cnt_d;
            cnt_q     <= cnt_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    // Outputs decode directly from flops; the address add wraps modulo 2^AW.
    assign rom_en    = (state_q == ST_RUN);
    assign rom_addr  = rom_en ? (base_q + off_q) : '0;
    assign eng_clr   = (state_q == ST_LOAD);
    assign eng_valid = rd_pipe_q[ROM_LAT-1];
    assign eng_bit   = eng_valid && rom_data[0];
    assign res_valid = (state_q == ST_REPORT);
    assign res_id    = job_id_q;
    assign res_count = cnt_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    // Only bit 0 of the ROM word feeds the engine.
    assign rom_data_unused = ^rom_data[DW-1:1];

endmodule

// File: tb/tb_ptm_scan_ctrl.sv
// tb_ptm_scan_ctrl
//   Directed bench for ptm_scan_ctrl. A ROM model filled with repeats of the
//   bit pattern 1010011 and an engine model that flags each complete
//   occurrence of that pattern since its last clear drive two instances: the
//   default configuration and a CW=3 instance for counter saturation.
module tb_ptm_scan_ctrl;

    logic        clk;
    logic        rst;

    // Main instance (CW=10)
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_base, cmd_len;
    logic        rom_en;
    logic [9:0]  rom_addr, rom_data;
    logic        eng_clr, eng_valid, eng_bit, eng_hit;
    logic        res_valid, res_ready;
    logic [1:0]  res_id;
    logic [9:0]  res_count;
    logic        busy;

    // Saturation instance (CW=3)
    logic        s_cmd_valid, s_cmd_ready;
    logic [9:0]  s_cmd_base, s_cmd_len;
    logic        s_rom_en;
    logic [9:0]  s_rom_addr, s_rom_data;
    logic        s_eng_clr, s_eng_valid, s_eng_bit, s_eng_hit;
    logic        s_res_valid, s_res_ready;
    logic [1:0]  s_res_id;
    logic [2:0]  s_res_count;
    logic        s_busy;

    logic [9:0]  rom_mem [1024];
    logic [6:0]  patv;
    logic [6:0]  hist, s_hist;

    int checks = 0;
    int errors = 0;

    ptm_scan_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .eng_clr(eng_clr), .eng_valid(eng_valid), .eng_bit(eng_bit), .eng_hit(eng_hit),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count),
        .busy(busy)
    );

    ptm_scan_ctrl #(.CW(3)) dut_sat (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_base(s_cmd_base), .cmd_len(s_cmd_len), .cmd_ready(s_cmd_ready),
        .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .eng_clr(s_eng_clr), .eng_valid(s_eng_valid), .eng_bit(s_eng_bit), .eng_hit(s_eng_hit),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_id(s_res_id), .res_count(s_res_count),
        .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: one-cycle registered read
    always @(posedge clk) begin
        if (rom_en)   rom_data   <= rom_mem[rom_addr];
        if (s_rom_en) s_rom_data <= rom_mem[s_rom_addr];
    end

    // Engine models: 7-symbol history, hit when the window equals the pattern
    always @(posedge clk) begin
        if (eng_clr)        hist <= '0;
        else if (eng_valid) hist <= {hist[5:0], eng_bit};
        if (s_eng_clr)        s_hist <= '0;
        else if (s_eng_valid) s_hist <= {s_hist[5:0], s_eng_bit};
    end
    assign eng_hit   = eng_valid   && ({hist[5:0], eng_bit} == patv);
    assign s_eng_hit = s_eng_valid && ({s_hist[5:0], s_eng_bit} == patv);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] w;
        patv = 7'b1010011;
        hist = '0;
        s_hist = '0;
        rom_data = '0;
        s_rom_data = '0;
        for (int a = 0; a < 1024; a++) begin
            w = 10'(a);
            w[0] = patv[6 - (a % 7)];
            rom_mem[a] = w;
        end

        rst = 1'b1;
        cmd_valid = 0; cmd_base = '0; cmd_len = '0; res_ready = 0;
        s_cmd_valid = 0; s_cmd_base = '0; s_cmd_len = '0; s_res_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_eng_clr", eng_clr, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_count", res_count, 0);

        // Job 0: base 0, len 7 -> one hit
        cmd_valid = 1; cmd_base = 10'd0; cmd_len = 10'd7; res_ready = 1;
        @(negedge clk);
        cmd_valid = 0;
        chk("t1_eng_clr", eng_clr, 1);
        chk("t1_load_rom_en", rom_en, 0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t1_rom_en", rom_en, 1);
            chk("t1_rom_addr", rom_addr, k);
            chk("t1_eng_valid", eng_valid, (k > 0) ? 1 : 0);
        end
        @(negedge clk);
        chk("t1_drain_eng_valid", eng_valid, 1);
        chk("t1_drain_rom_en", rom_en, 0);
        chk("t1_drain_res_valid", res_valid, 0);
        @(negedge clk);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_id", res_id, 0);
        chk("t1_res_count", res_count, 1);
        @(negedge clk);
        chk("t1_idle_res_valid", res_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // Job 1: len 0 -> result two cycles after accept, count 0
        cmd_valid = 1; cmd_base = 10'd5; cmd_len = 10'd0;
        @(negedge clk);
        cmd_valid = 0;
        chk("t2_eng_clr", eng_clr, 1);
        chk("t2_rom_en", rom_en, 0);
        @(negedge clk);
        chk("t2_res_valid", res_valid, 1);
        chk("t2_res_id", res_id, 1);
        chk("t2_res_count", res_count, 0);
        chk("t2_rom_en_rep", rom_en, 0);
        chk("t2_eng_valid", eng_valid, 0);
        @(negedge clk);

        // Job 2: address wrap, base 1020 len 6
        cmd_valid = 1; cmd_base = 10'd1020; cmd_len = 10'd6;
        @(negedge clk);
        cmd_valid = 0;
        chk("t3_eng_clr", eng_clr, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_rom_addr", rom_addr, (1020 + k) % 1024);
        end
        @(negedge clk);
        chk("t3_drain_rom_en", rom_en, 0);
        @(negedge clk);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_res_id", res_id, 2);
        chk("t3_res_count", res_count, 0);
        @(negedge clk);

        // Reset in the middle of a RUN
        cmd_valid = 1; cmd_base = 10'd0; cmd_len = 10'd7;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_pre_rom_en", rom_en, 1);
        chk("t4_pre_rom_addr", rom_addr, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rom_en", rom_en, 0);
        chk("t4_res_valid", res_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_cmd_ready", cmd_ready, 1);
        chk("t4_eng_valid", eng_valid, 0);

        // Five back-to-back commands with results blocked
        res_ready = 0;
        for (int j = 0; j < 5; j++) begin
            cmd_valid = 1; cmd_base = 10'(j % 2); cmd_len = 10'd7;
            chk("t5_cmd_ready", cmd_ready, 1);
            @(negedge clk);
        end
        cmd_base = 10'd2; cmd_len = 10'd3;
        chk("t5_full", cmd_ready, 0);
        @(negedge clk);
        chk("t5_full2", cmd_ready, 0);
        cmd_valid = 0;
        for (int n = 0; n < 30 && res_valid !== 1'b1; n++) @(negedge clk);
        chk("t5_first_valid", res_valid, 1);
        repeat (2) @(negedge clk);
        chk("t5_hold_valid", res_valid, 1);
        chk("t5_hold_id", res_id, 0);
        chk("t5_hold_count", res_count, 1);
        res_ready = 1;
        for (int j = 0; j < 5; j++) begin
            for (int n = 0; n < 30 && res_valid !== 1'b1; n++) @(negedge clk);
            chk("t5_res_valid", res_valid, 1);
            chk("t5_res_id", res_id, j % 4);
            chk("t5_res_count", res_count, (j % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        chk("t5_end_busy", busy, 0);

        // Saturation on the CW=3 instance: 420 words -> 60 hits
        s_cmd_valid = 1; s_cmd_base = 10'd0; s_cmd_len = 10'd420; s_res_ready = 1;
        @(negedge clk);
        s_cmd_valid = 0;
        for (int n = 0; n < 500 && s_res_valid !== 1'b1; n++) @(negedge clk);
        chk("t6_res_valid", s_res_valid, 1);
        chk("t6_res_id", s_res_id, 0);
        chk("t6_res_count", s_res_count, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
